captura_perfil: RTL and testbench

Front-end capture stage for the profile selection path. It samples the three profile switches and the confirm/cancel buttons, synchronises and debounces the buttons, and validates the selected code. On a valid confirm it presents the profile bits plus a validity flag for a bounded window. Its outputs drive the profile-transfer stage: `perfil[2:0]` feeds the three profile-bit inputs and `perfil_valido` feeds the enable input, so that stage passes the profile only while it is valid and outputs 000 otherwise.

---
 rtl/captura_perfil.sv | 205 ++++++++++++++++++++
 tb/tb_captura_perfil.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/captura_perfil.sv
`default_nettype none
// ============================================================================
// Module   : captura_perfil
// Brief    : Profile capture front-end: synchronise, debounce and validate a
//            confirmed switch code, then present it for a bounded window.
// Revision : 1.0 - initial release
// ============================================================================
module captura_perfil #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int ERR_CYCLES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       btn_confirma,
  input  logic       btn_cancela,
  output logic [2:0] perfil,
  output logic       perfil_valido,
  output logic       erro,
  output logic [1:0] estado
);

  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > ERR_CYCLES) ? HOLD_CYCLES : ERR_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [DW-1:0] C_DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] C_DB_ONE    = DW'(1);
  localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_ERR_LAST  = CW'(ERR_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_ERRO = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // Switch synchroniser
  // --------------------------------------------------------------------------
  logic [2:0] r_sw_meta;
  logic [2:0] r_sw_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= 3'b000;
      r_sw_sync <= 3'b000;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Button synchroniser, debounce and rising-edge pulse (bit 0 confirm,
  // bit 1 cancel)
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_pulse;

  assign w_btn_raw = {btn_cancela, btn_confirma};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_level_d;
    logic          r_pulse;
    logic [DW-1:0] r_cnt;

    // The level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, so it needs that many consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_pulse   <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_meta    <= w_btn_raw[gi];
        r_sync    <= r_meta;
        r_level_d <= r_level;
        r_pulse   <= r_level & ~r_level_d;
        if (r_sync != r_level) begin
          if (r_cnt == C_DB_LAST) begin
            r_level <= r_sync;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_DB_ONE;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_pulse[gi] = r_pulse;
  end

  logic w_conf_p;
  logic w_canc_p;
  logic w_sw_valid;

  assign w_conf_p   = w_pulse[0];
  assign w_canc_p   = w_pulse[1];
  assign w_sw_valid = (r_sw_sync != 3'b000) && (r_sw_sync != 3'b111);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_perfil;
  logic [2:0]    w_perfil_nxt;
  logic          r_valido;
  logic          w_valido_nxt;
  logic          r_erro;
  logic          w_erro_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_perfil <= 3'b000;
      r_valido <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_perfil <= w_perfil_nxt;
      r_valido <= w_valido_nxt;
      r_erro   <= w_erro_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_perfil_nxt = r_perfil;
    w_valido_nxt = r_valido;
    w_erro_nxt   = r_erro;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt    = '0;
        w_perfil_nxt = 3'b000;
        w_valido_nxt = 1'b0;
        w_erro_nxt   = 1'b0;
        // Cancel wins over a simultaneous confirm.
        if (!w_canc_p && w_conf_p) begin
          if (w_sw_valid) begin
            w_perfil_nxt = r_sw_sync;
            w_valido_nxt = 1'b1;
            w_state_nxt  = ST_HOLD;
          end else begin
            w_erro_nxt  = 1'b1;
            w_state_nxt = ST_ERRO;
          end
        end
      end

      ST_HOLD: begin
        if (w_canc_p || (r_cnt == C_HOLD_LAST)) begin
          w_state_nxt  = ST_IDLE;
          w_cnt_nxt    = '0;
          w_perfil_nxt = 3'b000;
          w_valido_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_ERRO: begin
        if (w_canc_p || (r_cnt == C_ERR_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_erro_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = '0;
        w_perfil_nxt = 3'b000;
        w_valido_nxt = 1'b0;
        w_erro_nxt   = 1'b0;
      end
    endcase
  end

  assign perfil        = r_perfil;
  assign perfil_valido = r_valido;
  assign erro          = r_erro;
  assign estado        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_captura_perfil.sv
`default_nettype none
// ============================================================================
// Module   : tb_captura_perfil
// Brief    : Randomised and directed stimulus for captura_perfil, compared
//            each cycle against a window/countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_captura_perfil;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int ERR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       btn_confirma = 1'b0;
  logic       btn_cancela = 1'b0;
  logic [2:0] perfil;
  logic       perfil_valido;
  logic       erro;
  logic [1:0] estado;

  always #5 clk = ~clk;

  captura_perfil #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .ERR_CYCLES     (ERR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_confirma (btn_confirma),
    .btn_cancela  (btn_cancela),
    .perfil       (perfil),
    .perfil_valido(perfil_valido),
    .erro         (erro),
    .estado       (estado)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 valid window, 2 error window, with a
  // countdown of cycles left; a button level flips once the last DEB
  // synchronised samples all disagree with it.
  int             m_mode;
  int             m_left;
  logic [2:0]     m_perfil;
  logic [2:0]     m_sw1, m_sw_sync;
  logic [1:0]     m_b1, m_bsync, m_lvl, m_lvl_old, m_pulse;
  logic [DEB-1:0] m_hist [2];

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_perfil = 3'b000;
    m_sw1 = 3'b000; m_sw_sync = 3'b000;
    m_b1 = 2'b00; m_bsync = 2'b00; m_lvl = 2'b00; m_lvl_old = 2'b00; m_pulse = 2'b00;
    m_hist[0] = '0; m_hist[1] = '0;
  endtask

  task automatic model_step(input logic [2:0] s, input logic [1:0] b, input logic r);
    if (r) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (m_pulse[0] && !m_pulse[1]) begin
        if (m_sw_sync != 3'd0 && m_sw_sync != 3'd7) begin
          m_mode = 1; m_left = HOLD; m_perfil = m_sw_sync;
        end else begin
          m_mode = 2; m_left = ERR;
        end
      end
    end else begin
      m_left--;
      if (m_pulse[1] || m_left == 0) begin
        m_mode = 0; m_perfil = 3'b000;
      end
    end
    m_pulse   = m_lvl & ~m_lvl_old;
    m_lvl_old = m_lvl;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = {m_hist[i][DEB-2:0], m_bsync[i]};
      if (!m_lvl[i] && m_hist[i] == {DEB{1'b1}}) m_lvl[i] = 1'b1;
      else if (m_lvl[i] && m_hist[i] == '0)      m_lvl[i] = 1'b0;
    end
    m_sw_sync = m_sw1;
    m_sw1     = s;
    m_bsync   = m_b1;
    m_b1      = b;
  endtask

  int edge_n      = 0;
  int n_valid_cyc = 0;
  int n_err_cyc   = 0;
  int n_busy_cyc  = 0;
  int first_valid = -1;
  int e0          = 0;

  // Called at a falling edge: check, drive, advance one rising edge.
  task automatic cycle(input logic [2:0] s, input logic c, input logic k, input logic r);
    chk("perfil",        32'(perfil),        32'(m_perfil));
    chk("perfil_valido", 32'(perfil_valido), 32'(m_mode == 1));
    chk("erro",          32'(erro),          32'(m_mode == 2));
    chk("estado",        32'(estado),        32'(m_mode));
    if (perfil_valido) n_valid_cyc++;
    if (erro) n_err_cyc++;
    if (estado != 2'b00) n_busy_cyc++;
    if (perfil_valido && first_valid < 0) first_valid = edge_n;
    sw = s; btn_confirma = c; btn_cancela = k; rst = r;
    if (r) begin
      #1;
      chk("rst_async_perfil", 32'(perfil),        0);
      chk("rst_async_valido", 32'(perfil_valido), 0);
      chk("rst_async_erro",   32'(erro),          0);
      chk("rst_async_estado", 32'(estado),        0);
    end
    @(posedge clk);
    model_step(s, {k, c}, r);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [2:0] s, input logic c, input logic k);
    for (int i = 0; i < n; i++) cycle(s, c, k, 1'b0);
  endtask

  task automatic clear_tallies();
    n_valid_cyc = 0; n_err_cyc = 0; n_busy_cyc = 0; first_valid = -1;
  endtask

  logic [2:0] rs;
  logic       rc, rk, rr;

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_noclk_perfil", 32'(perfil),        0);
    chk("rst_noclk_valido", 32'(perfil_valido), 0);
    chk("rst_noclk_erro",   32'(erro),          0);
    chk("rst_noclk_estado", 32'(estado),        0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) cycle(3'b000, i[0], ~i[0], 1'b1);

    // Valid confirm, sw=101
    run(5, 3'b101, 1'b0, 1'b0);
    clear_tallies(); e0 = edge_n + 1;
    run(10, 3'b101, 1'b1, 1'b0);
    run(12, 3'b101, 1'b0, 1'b0);
    chk("valid_len", n_valid_cyc, HOLD);
    chk("valid_latency", first_valid - e0, 7);

    // Invalid confirms, sw=111 then 000
    run(5, 3'b111, 1'b0, 1'b0);
    clear_tallies();
    run(8, 3'b111, 1'b1, 1'b0);
    run(10, 3'b111, 1'b0, 1'b0);
    chk("err_len_111", n_err_cyc, ERR);
    chk("err_novalid_111", n_valid_cyc, 0);
    run(5, 3'b000, 1'b0, 1'b0);
    clear_tallies();
    run(8, 3'b000, 1'b1, 1'b0);
    run(10, 3'b000, 1'b0, 1'b0);
    chk("err_len_000", n_err_cyc, ERR);

    // Bounce: high 3, low 1, high 3, low
    run(5, 3'b101, 1'b0, 1'b0);
    clear_tallies();
    run(3, 3'b101, 1'b1, 1'b0);
    run(1, 3'b101, 1'b0, 1'b0);
    run(3, 3'b101, 1'b1, 1'b0);
    run(12, 3'b101, 1'b0, 1'b0);
    chk("bounce_idle", n_busy_cyc, 0);

    // Cancel pulse lands in the third HOLD cycle
    run(5, 3'b010, 1'b0, 1'b0);
    clear_tallies();
    run(3, 3'b010, 1'b1, 1'b0);
    run(6, 3'b010, 1'b1, 1'b1);
    run(1, 3'b010, 1'b1, 1'b0);
    run(15, 3'b010, 1'b0, 1'b0);
    chk("cancel_len", n_valid_cyc, 3);

    // Second confirm while holding, with the switches changed
    clear_tallies();
    run(4, 3'b010, 1'b1, 1'b0);
    run(4, 3'b110, 1'b0, 1'b0);
    run(10, 3'b110, 1'b1, 1'b0);
    run(15, 3'b110, 1'b0, 1'b0);
    chk("reconfirm_len", n_valid_cyc, HOLD);

    // Async reset mid-HOLD with confirm held through it
    run(5, 3'b011, 1'b0, 1'b0);
    run(10, 3'b011, 1'b1, 1'b0);
    chk("pre_rst_hold", 32'(estado), 1);
    cycle(3'b011, 1'b1, 1'b0, 1'b1);
    cycle(3'b011, 1'b1, 1'b0, 1'b1);
    clear_tallies(); e0 = edge_n + 1;
    run(12, 3'b011, 1'b1, 1'b0);
    chk("rst_repress_latency", first_valid - e0, 7);
    run(15, 3'b011, 1'b0, 1'b0);

    // Randomised traffic
    rs = 3'b000; rc = 1'b0; rk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0) rs = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
        else rs = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 6) == 0) rc = ~rc;
      if ($urandom_range(0, 9) == 0) rk = ~rk;
      rr = ($urandom_range(0, 399) == 0);
      cycle(rs, rc, rk, rr);
    end
    run(20, 3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
